// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: radix-2 iterative multiply/divide for the RISC-V M extension.
// One multiplier/quotient bit per cycle over operand magnitudes, sign fix-up
// folded into the last iteration, fast path for divide-by-zero and overflow.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      inOp,
  input  logic [XLEN-1:0] inA,
  input  logic [XLEN-1:0] inB,
  input  logic            kill,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outResult,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;   // negate product/quotient/remainder at the end
  logic [XLEN-1:0]   opb;   // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0] acc;   // mul: {partial hi, multiplier}; div: {rem, quotient}

  // ---------------- request decode ----------------
  logic            sa_in, sb_in, neg_in, divz, ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  // operand signedness and fast-path detection for the incoming request
  always_comb begin
    sa_in = 1'b0;
    sb_in = 1'b0;
    case (inOp)
      OP_MULH, OP_DIV, OP_REM: begin
        sa_in = inA[XLEN-1];
        sb_in = inB[XLEN-1];
      end
      OP_MULHSU: sa_in = inA[XLEN-1];
      default: ;
    endcase
    mag_a  = sa_in ? -inA : inA;
    mag_b  = sb_in ? -inB : inB;
    // remainder follows the dividend; everything else follows sign parity
    neg_in = (inOp == OP_REM) ? sa_in : (sa_in ^ sb_in);
    divz   = (inB == '0);
    ovf    = ((inOp == OP_DIV) || (inOp == OP_REM)) &&
             (inA == {1'b1, {(XLEN-1){1'b0}}}) && (inB == '1);
    fast   = inOp[2] && (divz || ovf);
    if (divz) fast_res = inOp[1] ? inA : '1;
    else      fast_res = inOp[1] ? '0  : inA;
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]     sum, shhi, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, prod;
  logic [XLEN-1:0]   mul_res, div_raw, div_res, fin_res;

  // next accumulator for shift-add or restoring-divide, plus final result
  always_comb begin
    // multiply: add multiplicand into the high half when the low bit is set, shift right
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nx = {sum, acc[XLEN-1:1]};
    // divide: shift {rem,quo} left, trial-subtract divisor, keep if no borrow
    shhi   = acc[2*XLEN-1:XLEN-1];
    diff   = shhi - {1'b0, opb};
    if (!diff[XLEN]) div_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else             div_nx = {shhi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_nx = op[2] ? div_nx : mul_nx;

    prod    = neg ? -acc_nx : acc_nx;
    mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_raw = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    div_res = neg ? -div_raw : div_raw;
    fin_res = op[2] ? div_res : mul_res;
  end

  // control FSM, engine registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      neg       <= 1'b0;
      opb       <= '0;
      acc       <= '0;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      busy      <= 1'b0;
      outResult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid && inReady && !kill) begin
            op      <= inOp;
            neg     <= neg_in;
            inReady <= 1'b0;
            busy    <= 1'b1;
            if (inOp[2]) begin
              acc <= {{XLEN{1'b0}}, mag_a};
              opb <= mag_b;
            end else begin
              acc <= {{XLEN{1'b0}}, mag_b};
              opb <= mag_a;
            end
            if (fast) begin
              state     <= DONE;
              outResult <= fast_res;
              outValid  <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CW'(XLEN-1);
            end
          end
        end
        CALC: begin
          if (kill) begin
            state   <= IDLE;
            inReady <= 1'b1;
            busy    <= 1'b0;
          end else begin
            acc <= acc_nx;
            if (cnt == '0) begin
              state     <= DONE;
              outResult <= fin_res;
              outValid  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          if (kill || outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
            inReady  <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
          inReady  <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
